// File: rtl/mips_multicycle_controller_pkg.sv
// mips_mc_pkg: shared types and constants for the multicycle MIPS controller.
//   statetype   - FSM state encoding (FETCH..JEX, plus TRAP for the illegal-op trap build)
//   OP_*        - primary opcodes recognised in DECODE
//   ALUOP_*     - internal main-decoder to ALU-decoder selector
//   ALU_*       - ALU control codes driven to the datapath
//   FUNCT_*     - R-type funct codes
// Build option: MC_ILLEGAL_TRAP_EN selects whether TRAP is ever entered (see mc_maindec).
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPEEX,
        RTYPEWB,
        BEQEX,
        BGEEX,
        ADDIEX,
        ADDIWB,
        JEX,
        TRAP
    } statetype;

    // The controller always restarts instruction sequencing from FETCH.
    localparam statetype RESET_STATE = FETCH;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGE   = 6'b110000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_BGE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_controller_aludec.sv
// aludec: maps the main decoder's aluop plus the R-type funct field onto the
// 3-bit ALU control code.
//   funct      in  6  IR[5:0]
//   aluop      in  2  00 add, 01 sub, 10 decode funct
//   alucontrol out 3  ALU operation select
module aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    // Unrecognised funct codes leave the ALU operation undefined; the
    // write-back still happens, so software must not rely on the result.
    always_comb begin
        alucontrol = 3'bxxx;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = 3'bxxx;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller_maindec.sv
// mc_maindec: state machine of the multicycle controller plus the per-state
// decode of every datapath enable and mux select.
//   clk, reset        - clock, synchronous active-high reset
//   op                - IR[31:26]
//   pcwrite/branch/branchge - PC update requests (combined into pcen by the top)
//   memwrite, irwrite, regwrite - write strobes
//   alusrca, alusrcb, pcsrc, iord, memtoreg, regdst - mux selects
//   aluop             - to aludec
//   instr_done        - high on the final cycle of each instruction
//   illegal_op        - sticky trap flag (MC_ILLEGAL_TRAP_EN builds only)
// Build option: with MC_ILLEGAL_TRAP_EN defined an unknown opcode parks the
// FSM in TRAP until reset; otherwise it retires as a two-cycle NOP.
module mc_maindec
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       branch,
    output logic       branchge,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] aluop,
    output logic       instr_done,
    output logic       illegal_op
);

    statetype state, nextstate;

    always_ff @(posedge clk) begin
        if (reset) state <= RESET_STATE;
        else       state <= nextstate;
    end

    always_comb begin
        nextstate = FETCH;
        case (state)
            FETCH:   nextstate = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nextstate = MEMADR;
                    OP_RTYPE:     nextstate = RTYPEEX;
                    OP_BEQ:       nextstate = BEQEX;
                    OP_BGE:       nextstate = BGEEX;
                    OP_ADDI:      nextstate = ADDIEX;
                    OP_J:         nextstate = JEX;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      nextstate = TRAP;
`else
                    default:      nextstate = FETCH;
`endif
                endcase
            end
            MEMADR:  nextstate = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nextstate = MEMWB;
            RTYPEEX: nextstate = RTYPEWB;
            ADDIEX:  nextstate = ADDIWB;
`ifdef MC_ILLEGAL_TRAP_EN
            TRAP:    nextstate = TRAP;
`endif
            // Last cycles of every instruction, and any stray encoding, return to FETCH.
            default: nextstate = FETCH;
        endcase
    end

    // Moore output decode. Write strobes and PC requests are suppressed while
    // reset is high so an instruction aborted by reset leaves no partial effect.
    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchge   = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        aluop      = ALUOP_ADD;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alusrcb = 2'b11;
`ifndef MC_ILLEGAL_TRAP_EN
                instr_done = ~is_known_op(op);
`endif
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            BGEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branchge   = 1'b1;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcwrite    = 1'b0;
            branch     = 1'b0;
            branchge   = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Set on entry to TRAP, so the flag is already high in the first TRAP cycle.
    always_ff @(posedge clk) begin
        if (reset)                  illegal_q <= 1'b0;
        else if (nextstate == TRAP) illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: control unit for the shared-memory multicycle
// MIPS datapath. Sequences lw, sw, R-type, beq, bge, addi and j over 3-5 cycles.
//   clk, reset   - clock, synchronous active-high reset
//   op, funct    - IR[31:26], IR[5:0]
//   zero, bge    - datapath compare flags used by beq / bge
//   pcen, memwrite, irwrite, regwrite - write enables
//   alusrca, alusrcb, pcsrc, iord, memtoreg, regdst, alucontrol - datapath selects
//   instr_done   - one-cycle pulse on the last cycle of each instruction
//   illegal_op   - sticky illegal-opcode flag
// Build option: MC_ILLEGAL_TRAP_EN enables the illegal-opcode TRAP state.
module mips_multicycle_controller
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       bge,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal_op
);

    logic       pcwrite;
    logic       branch;
    logic       branchge;
    logic [1:0] aluop;

    mc_maindec u_maindec (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .branchge   (branchge),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .aluop      (aluop),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

    // Conditional branches only take effect when their datapath flag agrees.
    assign pcen = pcwrite | (branch & zero) | (branchge & bge);

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed bench for the multicycle controller.
// Expected outputs come from an instruction-level model: each instruction is
// a list of cycle indices, and the model derives every control output from
// the opcode, funct, flags and the cycle index within the instruction.
module tb_mips_multicycle_controller;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       bge;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal_op;

    int testCount = 0;
    int failCount = 0;

    logic       checkEn = 1'b0;
    logic       mReset;
    logic [5:0] mOp, mFunct;
    logic       mZero, mBge;
    int         mIdx;

    mips_multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .bge        (bge),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alucontrol (alucontrol),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic int latency(input logic [5:0] o);
        case (o)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b110000, 6'b000010: return 3;
            default:                         return TRAP_EN ? 100000 : 2;
        endcase
    endfunction

    function automatic logic [2:0] functAlu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'bxxx;
        endcase
    endfunction

    // Returns {illegal_op, pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
    //          pcsrc, iord, memtoreg, regdst, alucontrol, instr_done}.
    function automatic logic [16:0] model(input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input logic b, input int idx);
        logic isLw   = (o == 6'b100011);
        logic isSw   = (o == 6'b101011);
        logic isR    = (o == 6'b000000);
        logic isBeq  = (o == 6'b000100);
        logic isBge  = (o == 6'b110000);
        logic isAddi = (o == 6'b001000);
        logic isJ    = (o == 6'b000010);
        logic legal  = isLw | isSw | isR | isBeq | isBge | isAddi | isJ;
        logic last   = (idx == latency(o) - 1);
        logic exec   = legal && (idx == 2);
        logic trapped = TRAP_EN && !legal && (idx >= 2);
        logic       ePcen, eMemw, eIrw, eRegw, eSrca, eIord, eMtr, eDst, eDone;
        logic [1:0] eSrcb, ePcsrc;
        logic [2:0] eAlu;
        ePcen  = (idx == 0) || (exec && (isJ || (isBeq && z) || (isBge && b)));
        eMemw  = last && isSw;
        eIrw   = (idx == 0);
        eRegw  = last && (isLw || isR || isAddi);
        eSrca  = exec && !isJ;
        eSrcb  = (idx == 0) ? 2'b01 : (idx == 1) ? 2'b11 :
                 (exec && (isLw || isSw || isAddi)) ? 2'b10 : 2'b00;
        ePcsrc = !exec ? 2'b00 : isJ ? 2'b10 : (isBeq || isBge) ? 2'b01 : 2'b00;
        eIord  = (idx == 3) && (isLw || isSw);
        eMtr   = last && isLw;
        eDst   = last && isR;
        eAlu   = (exec && (isBeq || isBge)) ? 3'b110 : (exec && isR) ? functAlu(f) : 3'b010;
        eDone  = last;
        return {trapped, ePcen, eMemw, eIrw, eRegw, eSrca, eSrcb, ePcsrc,
                eIord, eMtr, eDst, eAlu, eDone};
    endfunction

    task automatic checkOutput(input string name, input logic [16:0] act, input logic [16:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Single compare process: every cycle, DUT against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            if (mReset)
                checkOutput("reset enables",
                            {12'b0, pcen, irwrite, regwrite, memwrite, instr_done}, 17'b0);
            else
                checkOutput($sformatf("op=%b funct=%b z=%0b b=%0b cycle=%0d",
                                      mOp, mFunct, mZero, mBge, mIdx),
                            {illegal_op, pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
                             pcsrc, iord, memtoreg, regdst, alucontrol, instr_done},
                            model(mOp, mFunct, mZero, mBge, mIdx));
        end
    end

    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input logic b);
        op = o; funct = f; zero = z; bge = b;
        mOp = o; mFunct = f; mZero = z; mBge = b;
        mIdx = 0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        mIdx++;
    endtask

    task automatic runInstr(input logic [5:0] o, input logic [5:0] f,
                            input logic z, input logic b);
        applyStimulus(o, f, z, b);
        repeat (latency(o)) stepCycle();
    endtask

    task automatic resetCycle();
        reset = 1'b1;
        mReset = 1'b1;
        @(negedge clk);
        checkOutput("regwrite in reset cycle", {16'b0, regwrite}, 17'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mReset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mReset = 1'b1;
        op = 6'b0; funct = 6'b0; zero = 1'b0; bge = 1'b0;
        mOp = 6'b0; mFunct = 6'b0; mZero = 1'b0; mBge = 1'b0; mIdx = 0;
        checkEn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; mReset = 1'b0;

        // lw: literal FETCH and MEMWB values
        applyStimulus(6'b100011, 6'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fetch irwrite/pcen/alusrcb", {14'b0, irwrite, pcen, alusrcb == 2'b01}, 17'b111);
        repeat (4) stepCycle();
        @(negedge clk);
        checkOutput("lw wb regwrite/memtoreg/done", {14'b0, regwrite, memtoreg, instr_done}, 17'b111);
        stepCycle();

        runInstr(6'b101011, 6'b0, 1'b0, 1'b0);

        // beq taken
        applyStimulus(6'b000100, 6'b0, 1'b1, 1'b0);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("beq taken pcen/pcsrc", {14'b0, pcen, pcsrc}, 17'b101);
        stepCycle();
        // beq not taken
        applyStimulus(6'b000100, 6'b0, 1'b0, 1'b0);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("beq not taken pcen", {16'b0, pcen}, 17'd0);
        stepCycle();

        // bge taken with zero=0
        applyStimulus(6'b110000, 6'b0, 1'b0, 1'b1);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("bge taken pcen/alucontrol", {13'b0, pcen, alucontrol}, 17'b1110);
        stepCycle();
        runInstr(6'b110000, 6'b0, 1'b0, 1'b0);
        runInstr(6'b110000, 6'b0, 1'b1, 1'b0);

        // R-type, every funct
        runInstr(6'b000000, 6'b100000, 1'b0, 1'b0);
        runInstr(6'b000000, 6'b100010, 1'b0, 1'b0);
        runInstr(6'b000000, 6'b100100, 1'b0, 1'b0);
        runInstr(6'b000000, 6'b100101, 1'b0, 1'b0);
        applyStimulus(6'b000000, 6'b101010, 1'b0, 1'b0);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("slt alucontrol", {14'b0, alucontrol}, 17'b111);
        stepCycle();
        @(negedge clk);
        checkOutput("rtype wb regdst/regwrite", {15'b0, regdst, regwrite}, 17'b11);
        stepCycle();

        runInstr(6'b001000, 6'b0, 1'b0, 1'b0);

        // j
        applyStimulus(6'b000010, 6'b0, 1'b0, 1'b0);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("j pcsrc/pcen", {14'b0, pcsrc, pcen}, 17'b101);
        stepCycle();

        // reset during MEMRD of lw
        applyStimulus(6'b100011, 6'b0, 1'b0, 1'b0);
        repeat (3) stepCycle();
        resetCycle();
        applyStimulus(6'b001000, 6'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fetch after abort irwrite", {16'b0, irwrite}, 17'd1);
        repeat (4) stepCycle();

        // illegal opcode
        if (TRAP_EN) begin
            applyStimulus(6'b111111, 6'b0, 1'b0, 1'b0);
            repeat (6) stepCycle();
            @(negedge clk);
            checkOutput("trap illegal_op/pcen", {15'b0, illegal_op, pcen}, 17'b10);
            resetCycle();
        end else begin
            runInstr(6'b111111, 6'b0, 1'b0, 1'b0);
        end
        runInstr(6'b101011, 6'b0, 1'b0, 1'b0);
        runInstr(6'b000010, 6'b0, 1'b0, 1'b0);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
